// File: rtl/hps_status_in.sv
// Avalon-MM status input port: synchronises a fabric status bus, exposes its live
// value, latches per-bit edge events (write-1-to-clear) and raises a maskable irq.
module hps_status_in #(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync_a_reg;
    logic [WIDTH-1:0] sync_b_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] edge_event;
    logic [1:0]       arm_cnt_reg;
    logic             armed;
    logic             wr_en;

    // Reads have no side effects, so the read strobe plays no part in the logic.
    logic unused_ok;
    assign unused_ok = &{1'b0, read_n, writedata};

    assign armed = (arm_cnt_reg == 2'd3);
    assign wr_en = chipselect & ~write_n;

    // Events are gated until armed so a level present at reset is never seen as an edge.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == 1) begin : g_fall
                assign edge_event[gi] = armed & ~sync_b_reg[gi] & prev_reg[gi];
            end else if (EDGE_TYPE == 2) begin : g_any
                assign edge_event[gi] = armed & (sync_b_reg[gi] ^ prev_reg[gi]);
            end else begin : g_rise
                assign edge_event[gi] = armed & sync_b_reg[gi] & ~prev_reg[gi];
            end
        end
    endgenerate

    // A new event on a bit being cleared wins, so nothing is lost in the collision.
    always_comb begin
        edgecap_next = edgecap_reg | edge_event;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            edgecap_next = (edgecap_reg & ~writedata[WIDTH-1:0]) | edge_event;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a_reg  <= '0;
            sync_b_reg  <= '0;
            prev_reg    <= '0;
            irqmask_reg <= '0;
            edgecap_reg <= '0;
            arm_cnt_reg <= 2'd0;
        end else begin
            sync_a_reg  <= in_port;
            sync_b_reg  <= sync_a_reg;
            prev_reg    <= sync_b_reg;
            edgecap_reg <= edgecap_next;
            if (!armed) begin
                arm_cnt_reg <= arm_cnt_reg + 2'd1;
            end
            if (wr_en && (address == ADDR_IRQMASK)) begin
                irqmask_reg <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync_b_reg;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_reg;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_hps_status_in.sv
// Directed bench for hps_status_in: a rising-edge instance and an any-edge instance
// share the same bus and inputs and are checked against hand-computed values.
module tb_hps_status_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata_r;
    logic [31:0] readdata_a;
    logic        irq_r;
    logic        irq_a;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hps_status_in #(.WIDTH(32), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata_r), .irq(irq_r)
    );

    hps_status_in #(.WIDTH(32), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata_a), .irq(irq_a)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("wr addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] dr, output logic [31:0] da);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1;
        dr         = readdata_r;
        da         = readdata_a;
        chipselect = 1'b0;
        read_n     = 1'b1;
        address    = 2'd0;
        $display("rd addr=%0d rise=%h any=%h", a, dr, da);
    endtask

    task automatic test_reset;
        logic [31:0] dr, da;
        in_port = 32'hFFFF_FFFF;
        reset   = 1'b1;
        tick(2);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], dr, da);
            n_vec++;
            if (dr !== 32'h0 || da !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read addr=%0d: got %h/%h want 0", a, dr, da);
            end
        end
        n_vec++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b/%b want 0", irq_r, irq_a);
        end
        reset = 1'b0;
        tick(1);
        rd(2'd0, dr, da);
        n_vec++;
        if (dr !== 32'h0) begin
            n_err++;
            $display("FAIL data_lat1: got %h want 00000000", dr);
        end
        tick(1);
        rd(2'd0, dr, da);
        n_vec++;
        if (dr !== 32'hFFFF_FFFF || da !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL data_lat2: got %h/%h want ffffffff", dr, da);
        end
        tick(8);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || da !== 32'h0 || irq_r !== 1'b0 || irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL arm_no_edge: edgecap %h/%h irq %b/%b want 0", dr, da, irq_r, irq_a);
        end
        in_port = 32'h0;
        reset   = 1'b1;
        tick(1);
        reset   = 1'b0;
        tick(5);
    endtask

    task automatic test_rise_irq;
        logic [31:0] dr, da;
        wr(2'd2, 32'h1);
        in_port[0] = 1'b1;
        tick(2);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL rise_early: edgecap %h irq %b want 0/0", dr, irq_r);
        end
        tick(1);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h1 || irq_r !== 1'b1) begin
            n_err++;
            $display("FAIL rise_edge3: edgecap %h irq %b want 1/1", dr, irq_r);
        end
        wr(2'd3, 32'h1);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL rise_clear: edgecap %h irq %b want 0/0", dr, irq_r);
        end
    endtask

    task automatic test_mask;
        logic [31:0] dr, da;
        wr(2'd2, 32'h0);
        in_port[5] = 1'b1;
        tick(4);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h20 || irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL mask_off: edgecap %h irq %b want 20/0", dr, irq_r);
        end
        wr(2'd2, 32'h20);
        n_vec++;
        if (irq_r !== 1'b1) begin
            n_err++;
            $display("FAIL mask_on: irq %b want 1", irq_r);
        end
        wr(2'd3, 32'h20);
        n_vec++;
        if (irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL mask_clear: irq %b want 0", irq_r);
        end
    endtask

    task automatic test_reserved;
        logic [31:0] dr, da;
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, dr, da);
        n_vec++;
        if (dr !== 32'h0 || da !== 32'h0) begin
            n_err++;
            $display("FAIL reserved_read: got %h/%h want 0", dr, da);
        end
        rd(2'd2, dr, da);
        n_vec++;
        if (dr !== 32'h20) begin
            n_err++;
            $display("FAIL reserved_mask: got %h want 00000020", dr);
        end
        rd(2'd0, dr, da);
        n_vec++;
        if (dr !== 32'h21) begin
            n_err++;
            $display("FAIL data_live: got %h want 00000021", dr);
        end
    endtask

    task automatic test_collision;
        logic [31:0] dr, da;
        wr(2'd2, 32'h4);
        in_port[2] = 1'b1;
        tick(2);
        wr(2'd3, 32'h4);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h4 || irq_r !== 1'b1) begin
            n_err++;
            $display("FAIL collision: edgecap %h irq %b want 4/1", dr, irq_r);
        end
        wr(2'd3, 32'h4);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL collision_clear: edgecap %h irq %b want 0/0", dr, irq_r);
        end
    endtask

    task automatic test_any_edge;
        logic [31:0] dr, da;
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h0);
        in_port[7] = 1'b1;
        tick(3);
        in_port[7] = 1'b0;
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h80 || da !== 32'h80) begin
            n_err++;
            $display("FAIL any_rise: got %h/%h want 80/80", dr, da);
        end
        wr(2'd3, 32'h80);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || da !== 32'h0) begin
            n_err++;
            $display("FAIL any_clear: got %h/%h want 0/0", dr, da);
        end
        tick(2);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || da !== 32'h80) begin
            n_err++;
            $display("FAIL any_fall: got %h/%h want 0/80", dr, da);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] dr, da, exp;
        int bits [3] = '{12, 20, 31};
        wr(2'd3, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            exp = 32'h1 << bits[k];
            in_port[bits[k]] = 1'b1;
            tick(1);
            in_port[bits[k]] = 1'b0;
            tick(4);
            rd(2'd3, dr, da);
            n_vec++;
            if (dr !== exp || da !== exp) begin
                n_err++;
                $display("FAIL glitch bit%0d: got %h/%h want %h", bits[k], dr, da, exp);
            end
            wr(2'd3, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] dr, da;
        in_port[3:0] = 4'h0;
        tick(4);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port[3:0] = 4'hF;
        tick(4);
        wr(2'd2, 32'hF);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'hF || da !== 32'hF || irq_r !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: edgecap %h/%h irq %b want f/f/1", dr, da, irq_r);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        in_port[8] = 1'b1;
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || da !== 32'h0 || irq_r !== 1'b0 || irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_cap: edgecap %h/%h irq %b/%b want 0", dr, da, irq_r, irq_a);
        end
        rd(2'd2, dr, da);
        n_vec++;
        if (dr !== 32'h0 || da !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset_mask: got %h/%h want 0", dr, da);
        end
        tick(1);
        in_port[9] = 1'b1;
        tick(2);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h0 || da !== 32'h0) begin
            n_err++;
            $display("FAIL unarmed: got %h/%h want 0", dr, da);
        end
        tick(1);
        rd(2'd3, dr, da);
        n_vec++;
        if (dr !== 32'h200 || da !== 32'h200) begin
            n_err++;
            $display("FAIL first_armed: got %h/%h want 200", dr, da);
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_port    = 32'h0;
        address    = 2'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = 32'h0;
        test_reset;
        test_rise_irq;
        test_mask;
        test_reserved;
        test_collision;
        test_any_edge;
        test_glitch;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
